packet_fifo: RTL and testbench

Packet-aware synchronous FIFO and the successor to the plain `fifo`. The write side stores words tentatively and commits them only on end-of-packet. Uncommitted words can be discarded with `drop_i`. The read side sees only committed words and gets a per-word end-of-packet flag, so downstream logic never starts on a partial packet.

---
 rtl/packet_fifo_if.sv | 44 ++++
 rtl/packet_fifo.sv | 189 ++++++++++++++++++
 tb/tb_packet_fifo.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_fifo_if.sv
// packet_fifo_if -- handshake/status bundle for packet_fifo.
//
// The signal names follow the packet_fifo port list so that the FIFO
// side reads the same as its datasheet.
//
//   write side : data_i, wrreq_i, eop_i, drop_i
//   read side  : rdreq_i, q_o, q_eop_o
//   status     : usedw_o, pkt_cnt_o, empty_o, full_o, almost_full_o,
//                almost_empty_o, drop_cnt_o
//
// Modports:
//   slave  -- the FIFO itself (consumes requests, drives status/data)
//   master -- the user (drives requests, observes status/data)
interface packet_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic [DWIDTH-1:0] data_i;
  logic              wrreq_i;
  logic              eop_i;
  logic              drop_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              q_eop_o;
  logic [AWIDTH:0]   usedw_o;
  logic [AWIDTH:0]   pkt_cnt_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [15:0]       drop_cnt_o;

  modport slave (
    input  data_i, wrreq_i, eop_i, drop_i, rdreq_i,
    output q_o, q_eop_o, usedw_o, pkt_cnt_o, empty_o, full_o,
           almost_full_o, almost_empty_o, drop_cnt_o
  );

  modport master (
    output data_i, wrreq_i, eop_i, drop_i, rdreq_i,
    input  q_o, q_eop_o, usedw_o, pkt_cnt_o, empty_o, full_o,
           almost_full_o, almost_empty_o, drop_cnt_o
  );
endinterface

// File: rtl/packet_fifo.sv
// packet_fifo -- packet-aware synchronous FIFO.
//
// Words are written tentatively and only become visible to the reader
// once the word carrying eop is accepted (commit). Uncommitted words can
// be discarded with drop_i. The reader sees committed words only, each
// with its end-of-packet flag, so it never starts on a partial packet.
//
// Ports:
//   clk_i   -- clock, all logic on the rising edge
//   arst_i  -- asynchronous active-high reset (control state only;
//              the storage array is not reset)
//   bus     -- packet_fifo_if.slave: write request/data/eop/drop,
//              read request, head word + eop, committed word and packet
//              counts, empty/full/almost flags, dropped-packet counter
//
// Build option:
//   PACKET_FIFO_OVERFLOW_DROP_EN -- when defined, a write while full
//   poisons the packet being written; writes are discarded until the
//   next eop write, which rolls the packet back and counts it as
//   dropped. When undefined, writes while full are ignored (eop too)
//   and a simulation assertion reports the overflow.
module packet_fifo #(
  parameter int DWIDTH             = 8,
  parameter int AWIDTH             = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 4
) (
  input  logic        clk_i,
  input  logic        arst_i,
  packet_fifo_if.slave bus
);

  localparam int              DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_LVL = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_LVL    = ALMOST_FULL_VALUE[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_LVL    = ALMOST_EMPTY_VALUE[AWIDTH:0];
  localparam logic [AWIDTH:0] PTR_ONE   = {{AWIDTH{1'b0}}, 1'b1};

  // Saturating increment for the dropped-packet counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Storage: {eop, data} per entry.
  logic [DWIDTH:0] mem [DEPTH];

  // Pointers carry one extra wrap bit; differences are modulo 2**(AWIDTH+1).
  logic [AWIDTH:0] rd_ptr;
  logic [AWIDTH:0] wr_ptr;
  logic [AWIDTH:0] commit_ptr;
  logic [AWIDTH:0] pkt_cnt;
  logic [15:0]     drop_cnt;
  logic            poison;

  logic [AWIDTH:0] used;
  logic [AWIDTH:0] total;
  logic            empty;
  logic            full;
  logic [DWIDTH:0] head;
  logic            pop;
  logic            pop_eop;

  // Next-state of the write side.
  logic [AWIDTH:0] wr_ptr_nxt;
  logic [AWIDTH:0] commit_ptr_nxt;
  logic            mem_we;
  logic            commit;
  logic            drop_hit;
  logic            poison_nxt;

  assign used    = commit_ptr - rd_ptr;
  assign total   = wr_ptr - rd_ptr;
  assign empty   = (used == '0);
  assign full    = (total == DEPTH_LVL);
  assign head    = mem[rd_ptr[AWIDTH-1:0]];
  assign pop     = bus.rdreq_i && !empty;
  assign pop_eop = pop && head[DWIDTH];

  // Write-side decision. drop_i has priority and discards any write in
  // the same cycle; otherwise an accepted write either just advances the
  // tentative pointer or, with eop, also moves the commit point.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    mem_we         = 1'b0;
    commit         = 1'b0;
    drop_hit       = 1'b0;
    poison_nxt     = poison;

    if (bus.drop_i) begin
      wr_ptr_nxt = commit_ptr;
      drop_hit   = (wr_ptr != commit_ptr);
      // The packet being written is abandoned, so any overflow mark on
      // it goes with it.
      poison_nxt = 1'b0;
    end else if (bus.wrreq_i) begin
`ifdef PACKET_FIFO_OVERFLOW_DROP_EN
      if (poison || full) begin
        // Overflowed packet: swallow words until its eop, then roll the
        // tentative pointer back and count the packet as dropped.
        if (bus.eop_i) begin
          wr_ptr_nxt = commit_ptr;
          poison_nxt = 1'b0;
          drop_hit   = 1'b1;
        end else begin
          poison_nxt = 1'b1;
        end
      end else begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (bus.eop_i) begin
          commit_ptr_nxt = wr_ptr + PTR_ONE;
          commit         = 1'b1;
        end
      end
`else
      if (!full) begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (bus.eop_i) begin
          commit_ptr_nxt = wr_ptr + PTR_ONE;
          commit         = 1'b1;
        end
      end
`endif
    end
  end

  // Control state: pointers, counters, overflow mark.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      poison     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      poison     <= poison_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop_hit) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      // A commit and a packet-completing read in the same cycle cancel.
      unique case ({commit, pop_eop})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_ptr[AWIDTH-1:0]] <= {bus.eop_i, bus.data_i};
    end
  end

  // Showahead head word, forced to zero while nothing is committed so
  // stale or uncommitted contents never leak out.
  assign bus.q_o            = empty ? '0 : head[DWIDTH-1:0];
  assign bus.q_eop_o        = empty ? 1'b0 : head[DWIDTH];
  assign bus.usedw_o        = used;
  assign bus.pkt_cnt_o      = pkt_cnt;
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_full_o  = (total >= AF_LVL);
  assign bus.almost_empty_o = (used < AE_LVL);
  assign bus.drop_cnt_o     = drop_cnt;

`ifndef PACKET_FIFO_OVERFLOW_DROP_EN
`ifndef SYNTHESIS
  // Without overflow dropping, a write while full silently breaks packet
  // integrity; flag it so the writer's bug is visible in simulation.
  always @(posedge clk_i) begin
    if (!arst_i) begin
      assert (!(bus.wrreq_i && full))
        else $warning("packet_fifo: write while full ignored");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_packet_fifo.sv
module tb_packet_fifo;

  logic clk;
  logic arst;
  bit   cmp_en;
  int   checks;
  int   errors;

  packet_fifo_if #(.DWIDTH(8), .AWIDTH(4)) bus ();

  packet_fifo #(
    .DWIDTH(8),
    .AWIDTH(4),
    .ALMOST_FULL_VALUE(12),
    .ALMOST_EMPTY_VALUE(4)
  ) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: committed and pending words as queues of {eop,data}.
  logic [8:0] cq[$];
  logic [8:0] pq[$];
  int         mdrop;
  bit         mpoison;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    mdrop   = 0;
    mpoison = 1'b0;
  endtask

  task automatic model_push(input bit eop, input logic [7:0] d);
    pq.push_back({eop, d});
    if (eop) begin
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
    end
  endtask

  task automatic model_edge(input bit wr, input bit eop, input logic [7:0] d,
                            input bit rd, input bit drp);
    bit mfull;
    mfull = ((cq.size() + pq.size()) == 16);
    if (rd && cq.size() > 0) void'(cq.pop_front());
    if (drp) begin
      if (pq.size() > 0 && mdrop < 65535) mdrop++;
      pq.delete();
      mpoison = 1'b0;
    end else if (wr) begin
`ifdef PACKET_FIFO_OVERFLOW_DROP_EN
      if (mpoison || mfull) begin
        if (eop) begin
          pq.delete();
          mpoison = 1'b0;
          if (mdrop < 65535) mdrop++;
        end else begin
          mpoison = 1'b1;
        end
      end else begin
        model_push(eop, d);
      end
`else
      if (!mfull) model_push(eop, d);
`endif
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      int np;
      int tot;
      np = 0;
      foreach (cq[i]) if (cq[i][8]) np++;
      tot = cq.size() + pq.size();
      chk("m_q",     32'(bus.q_o),            (cq.size() > 0) ? 32'(cq[0][7:0]) : 32'd0);
      chk("m_q_eop", 32'(bus.q_eop_o),        (cq.size() > 0) ? 32'(cq[0][8])   : 32'd0);
      chk("m_usedw", 32'(bus.usedw_o),        cq.size());
      chk("m_pkt",   32'(bus.pkt_cnt_o),      np);
      chk("m_empty", 32'(bus.empty_o),        (cq.size() == 0) ? 32'd1 : 32'd0);
      chk("m_full",  32'(bus.full_o),         (tot == 16) ? 32'd1 : 32'd0);
      chk("m_afull", 32'(bus.almost_full_o),  (tot >= 12) ? 32'd1 : 32'd0);
      chk("m_aempty",32'(bus.almost_empty_o), (cq.size() < 4) ? 32'd1 : 32'd0);
      chk("m_drop",  32'(bus.drop_cnt_o),     mdrop);
    end
  end

  task automatic cycle(input bit wr, input bit eop, input logic [7:0] d,
                       input bit rd, input bit drp);
    bus.wrreq_i = wr;
    bus.eop_i   = eop;
    bus.data_i  = d;
    bus.rdreq_i = rd;
    bus.drop_i  = drp;
    @(posedge clk);
    model_edge(wr, eop, d, rd, drp);
    #1;
    bus.wrreq_i = 1'b0;
    bus.eop_i   = 1'b0;
    bus.data_i  = 8'h00;
    bus.rdreq_i = 1'b0;
    bus.drop_i  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"},      32'(bus.q_o),            32'd0);
    chk({tag, "_q_eop"},  32'(bus.q_eop_o),        32'd0);
    chk({tag, "_usedw"},  32'(bus.usedw_o),        32'd0);
    chk({tag, "_pkt"},    32'(bus.pkt_cnt_o),      32'd0);
    chk({tag, "_empty"},  32'(bus.empty_o),        32'd1);
    chk({tag, "_full"},   32'(bus.full_o),         32'd0);
    chk({tag, "_afull"},  32'(bus.almost_full_o),  32'd0);
    chk({tag, "_aempty"}, 32'(bus.almost_empty_o), 32'd1);
    chk({tag, "_drop"},   32'(bus.drop_cnt_o),     32'd0);
  endtask

  // Asynchronous reset pulse placed between two clock edges.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    arst = 1'b1;
    model_reset();
    #1;
    chk_reset_vals({tag, "_in"});
    #1;
    arst = 1'b0;
    #1;
    chk_reset_vals({tag, "_out"});
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cmp_en      = 1'b0;
    arst        = 1'b1;
    bus.wrreq_i = 1'b0;
    bus.eop_i   = 1'b0;
    bus.data_i  = 8'h00;
    bus.rdreq_i = 1'b0;
    bus.drop_i  = 1'b0;
    model_reset();

    // Reset state
    #3;
    chk_reset_vals("rst");
    #4;
    arst   = 1'b0;
    cmp_en = 1'b1;

    // Three-word packet, commit on the last word
    cycle(1, 0, 8'h11, 0, 0);
    chk("p1_empty_w1", 32'(bus.empty_o), 32'd1);
    cycle(1, 0, 8'h22, 0, 0);
    chk("p1_empty_w2", 32'(bus.empty_o), 32'd1);
    chk("p1_usedw_w2", 32'(bus.usedw_o), 32'd0);
    cycle(1, 1, 8'h33, 0, 0);
    chk("p1_usedw", 32'(bus.usedw_o),   32'd3);
    chk("p1_pkt",   32'(bus.pkt_cnt_o), 32'd1);
    chk("p1_q0",    32'(bus.q_o),       32'h11);
    chk("p1_e0",    32'(bus.q_eop_o),   32'd0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("p1_q1",    32'(bus.q_o),       32'h22);
    chk("p1_e1",    32'(bus.q_eop_o),   32'd0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("p1_q2",    32'(bus.q_o),       32'h33);
    chk("p1_e2",    32'(bus.q_eop_o),   32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    chk("p1_pkt_end",   32'(bus.pkt_cnt_o), 32'd0);
    chk("p1_empty_end", 32'(bus.empty_o),   32'd1);

    // Drop of an uncommitted partial packet
    cycle(1, 0, 8'hA0, 0, 0);
    cycle(1, 0, 8'hA1, 0, 0);
    chk("drp_usedw_pre", 32'(bus.usedw_o), 32'd0);
    cycle(0, 0, 8'h00, 0, 1);
    chk("drp_usedw", 32'(bus.usedw_o),       32'd0);
    chk("drp_full",  32'(bus.full_o),        32'd0);
    chk("drp_afull", 32'(bus.almost_full_o), 32'd0);
    chk("drp_cnt",   32'(bus.drop_cnt_o),    32'd1);
    cycle(1, 1, 8'h55, 0, 0);
    chk("drp_q",     32'(bus.q_o),     32'h55);
    chk("drp_qeop",  32'(bus.q_eop_o), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    chk("drp_empty", 32'(bus.empty_o), 32'd1);

    // Fill with four 4-word packets
    for (int k = 0; k < 16; k++) begin
      cycle(1, (k % 4) == 3, 8'(8'h40 + k), 0, 0);
      if (k == 10) chk("fill_af11",   32'(bus.almost_full_o), 32'd0);
      if (k == 11) chk("fill_af12",   32'(bus.almost_full_o), 32'd1);
      if (k == 14) chk("fill_full15", 32'(bus.full_o),        32'd0);
    end
    chk("fill_full",  32'(bus.full_o),    32'd1);
    chk("fill_usedw", 32'(bus.usedw_o),   32'd16);
    chk("fill_pkt",   32'(bus.pkt_cnt_o), 32'd4);
    // Extra write while full is rejected
    cycle(1, 0, 8'hEE, 0, 0);
    chk("xtra_usedw", 32'(bus.usedw_o), 32'd16);
    chk("xtra_full",  32'(bus.full_o),  32'd1);
    chk("xtra_q",     32'(bus.q_o),     32'h40);
    // Read and write together at full: read wins
    cycle(1, 0, 8'hEF, 1, 0);
    chk("rw_usedw", 32'(bus.usedw_o), 32'd15);
    chk("rw_full",  32'(bus.full_o),  32'd0);
    for (int k = 1; k < 16; k++) begin
      chk("drain_q",   32'(bus.q_o),     32'(8'h40 + k));
      chk("drain_eop", 32'(bus.q_eop_o), ((k % 4) == 3) ? 32'd1 : 32'd0);
      cycle(0, 0, 8'h00, 1, 0);
    end
    chk("drain_empty", 32'(bus.empty_o),   32'd1);
    chk("drain_pkt",   32'(bus.pkt_cnt_o), 32'd0);
`ifdef PACKET_FIFO_OVERFLOW_DROP_EN
    // The rejected writes poisoned the open packet; an eop closes it out.
    cycle(1, 1, 8'h77, 0, 0);
    chk("clr_usedw", 32'(bus.usedw_o), 32'd0);
`endif

    // Empty-FIFO corner cases from a clean state
    async_reset("r2");
    cycle(0, 0, 8'h00, 1, 0);
    chk("rd_empty_usedw", 32'(bus.usedw_o), 32'd0);
    chk("rd_empty_flag",  32'(bus.empty_o), 32'd1);
    cycle(0, 0, 8'h00, 0, 1);
    chk("drop_none_cnt",  32'(bus.drop_cnt_o), 32'd0);
    cycle(1, 1, 8'h5A, 0, 0);
    chk("after_empty_q",  32'(bus.q_o), 32'h5A);
    cycle(0, 0, 8'h00, 1, 0);

`ifdef PACKET_FIFO_OVERFLOW_DROP_EN
    // Oversized packet is dropped rather than deadlocking
    async_reset("r3");
    for (int i = 1; i <= 20; i++) begin
      cycle(1, i == 20, 8'(8'h80 + i), 0, 0);
      if (i == 16) begin
        chk("ovf_full16",  32'(bus.full_o),  32'd1);
        chk("ovf_usedw16", 32'(bus.usedw_o), 32'd0);
      end
    end
    chk("ovf_usedw", 32'(bus.usedw_o),    32'd0);
    chk("ovf_full",  32'(bus.full_o),     32'd0);
    chk("ovf_drop",  32'(bus.drop_cnt_o), 32'd1);
    cycle(1, 0, 8'hC1, 0, 0);
    cycle(1, 1, 8'hC2, 0, 0);
    chk("ovf_q0", 32'(bus.q_o),     32'hC1);
    chk("ovf_e0", 32'(bus.q_eop_o), 32'd0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("ovf_q1", 32'(bus.q_o),     32'hC2);
    chk("ovf_e1", 32'(bus.q_eop_o), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    chk("ovf_empty", 32'(bus.empty_o), 32'd1);
`endif

    // Asynchronous reset mid-packet
    async_reset("r4");
    cycle(1, 0, 8'h60, 0, 0);
    cycle(0, 0, 8'h00, 0, 1);
    chk("ar_drop_pre", 32'(bus.drop_cnt_o), 32'd1);
    cycle(1, 0, 8'h61, 0, 0);
    cycle(1, 1, 8'h62, 0, 0);
    cycle(1, 0, 8'h63, 0, 0);
    cycle(1, 0, 8'h64, 0, 0);
    chk("ar_usedw_pre", 32'(bus.usedw_o),       32'd2);
    chk("ar_pkt_pre",   32'(bus.pkt_cnt_o),     32'd1);
    chk("ar_q_pre",     32'(bus.q_o),           32'h61);
    async_reset("r5");
    cycle(0, 0, 8'h00, 0, 0);
    chk("ar_empty_post", 32'(bus.empty_o), 32'd1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
